mix_output_controller: RTL

MIX_OUTPUT_CONTROLLER -- requirements
Module: mix_output_controller

---
 rtl/mix_output_controller_if.sv | 26 ++
 rtl/mix_output_controller.sv | 71 +++++++
 2 files changed

// File: rtl/mix_output_controller_if.sv
// mix_output_controller_if: data/handshake bundle between the mix stage, its feedback path and the dense stage
interface mix_output_controller_if #(
    parameter int HID_DIM = 4,
    parameter int N_LEN   = 16
);
    logic [HID_DIM*HID_DIM*N_LEN-1:0] d;
    logic                             valid_in;
    logic                             ready;
    logic [HID_DIM*HID_DIM*N_LEN-1:0] q_mix;
    logic                             valid_mix;
    logic [HID_DIM*N_LEN-1:0]         q_hid;
    logic                             valid_hid;
    logic [HID_DIM*HID_DIM*N_LEN-1:0] q_out;
    logic                             valid_out;
    logic                             ready_out;

    modport master (
        output d, valid_in, ready_out,
        input  ready, q_mix, valid_mix, q_hid, valid_hid, q_out, valid_out
    );

    modport slave (
        input  d, valid_in, ready_out,
        output ready, q_mix, valid_mix, q_hid, valid_hid, q_out, valid_out
    );
endinterface

// File: rtl/mix_output_controller.sv
// mix_output_controller: routes mix results to feedback, hidden latch or dense stage; MIX_OUT_OVF_EN adds a sticky overflow flag
module mix_output_controller #(
    parameter int HID_DIM   = 4,
    parameter int N_LEN     = 16,
    parameter int STATE_LEN = 3,
    parameter int MODE_LEN  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [STATE_LEN-1:0] state,
    input  logic [MODE_LEN-1:0]  mode,
    mix_output_controller_if.slave bus,
    output logic                 ovf
);
    typedef enum logic [STATE_LEN-1:0] {MIX1 = 1, MIX2 = 2, MIX3 = 3} top_state_t;
    typedef enum logic [MODE_LEN-1:0] {FORWARD, BACKWARD, GEN_SIMI, GEN_NEW} mode_t;
    typedef enum logic [1:0] {IDLE, FEEDBACK, OUT_WAIT} fsm_t;

    fsm_t                             fsm_q, fsm_d;
    logic [HID_DIM*HID_DIM*N_LEN-1:0] mat_q;
    logic [HID_DIM*N_LEN-1:0]         hid_q, col0;
    logic                             hid_v, is_mix, acc, hid_ld;

    // Column 0 of the incoming matrix becomes the latent hidden vector
    for (genvar i = 0; i < HID_DIM; i++) begin : g_col0
        assign col0[i*N_LEN +: N_LEN] = bus.d[HID_DIM*i*N_LEN +: N_LEN];
    end

    assign is_mix = state == MIX1 || state == MIX2 || state == MIX3;
    assign bus.ready = fsm_q != OUT_WAIT;
    assign acc = bus.valid_in && bus.ready && is_mix;
    assign hid_ld = acc && state == MIX2 && mode == FORWARD;

    always_comb begin
        fsm_d = IDLE;
        if (acc) fsm_d = state == MIX3 ? OUT_WAIT : FEEDBACK;
        else if (fsm_q == OUT_WAIT && !bus.ready_out) fsm_d = OUT_WAIT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= IDLE;
            mat_q <= '0;
            hid_q <= '0;
            hid_v <= 1'b0;
        end else begin
            fsm_q <= fsm_d;
            hid_v <= hid_ld;
            if (acc) mat_q <= bus.d;
            if (hid_ld) hid_q <= col0;
        end
    end

    assign bus.q_mix     = mat_q;
    assign bus.q_out     = mat_q;
    assign bus.q_hid     = hid_q;
    assign bus.valid_mix = fsm_q == FEEDBACK;
    assign bus.valid_hid = hid_v;
    assign bus.valid_out = fsm_q == OUT_WAIT;

`ifdef MIX_OUT_OVF_EN
    logic ovf_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else if (bus.valid_in && !bus.ready && is_mix) ovf_q <= 1'b1;
    end
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif
endmodule
